acc_seq_ctrl: RTL
=================

# acc_seq_ctrl

Parametrised sequencer for the MAC accumulator of a fully-connected layer in the MNIST inference datapath. It extends the fixed four-phase accumulator controller into a general controller:

- configurable taps per neuron and neurons per layer;
- start/busy/done handshake with the layer scheduler;
- input-valid stalling;
- optional bias-add phase.

It sits between the weight/pixel streamer and the accumulator and output register of one neuron lane.

## Interface
Parameters:
- N_TAPS, 4, products summed per neuron (≥1)
- N_NEURONS, 10, neurons sequenced per start (≥1)
- TAP_W, max(1,$clog2(N_TAPS)), derived width of tap_idx
- NEU_W, max(1,$clog2(N_NEURONS)), derived width of neu_idx

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a layer pass; sampled only in IDLE
- in_valid  in  1  streamer has a product this cycle
- in_ready  out  1  controller accepts a product (RUN state)
- mac_en  out  1  accumulator updates this cycle (in_valid && in_ready)
- sel  out  1  accumulator loads instead of adding (first tap of a neuron)
- bias_en  out  1  accumulator adds bias this cycle
- en  out  1  output register captures the finished sum
- tap_idx  out  TAP_W  current tap index
- neu_idx  out  NEU_W  current neuron index
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse, last neuron written

## Operation
- States: IDLE, RUN, BIAS (only with the macro), WRITE.
- IDLE: start=1 → RUN. tap_idx and neu_idx are both 0.
- RUN:
  - in_ready=1.
  - A beat is consumed when in_valid=1, giving mac_en=1.
  - sel = mac_en && tap_idx==0.
  - On consume: if tap_idx==N_TAPS-1, tap_idx wraps to 0 and state → BIAS (macro) or WRITE. Otherwise tap_idx increments.
  - in_valid=0: stall; no outputs asserted; counters hold.
- BIAS: bias_en=1 for exactly one cycle, independent of in_valid. Then → WRITE.
- WRITE:
  - en=1 for exactly one cycle.
  - If neu_idx==N_NEURONS-1: done=1, neu_idx → 0, state → IDLE.
  - Otherwise neu_idx increments, state → RUN.
- All outputs decode from registered state and counters, combined combinationally with in_valid only.
- start outside IDLE is ignored. This includes the cycle in which done=1.
- Reset values: state IDLE, tap_idx=0, neu_idx=0. in_ready, mac_en, sel, bias_en, en, busy, done all 0.

## Timing
- start sampled at edge 0 → RUN from cycle 1; the first sel may occur in cycle 1.
- With in_valid held high, neuron period is P = N_TAPS+1, or N_TAPS+2 with bias.
- Neuron k's en is at cycle (k+1)·P.
- done coincides with the last en, at cycle N_NEURONS·P.
  - Defaults without bias: cycle 50.
- Next start is accepted in the first IDLE cycle, at cycle N_NEURONS·P+1.
- Each stall cycle in RUN delays every subsequent event by one cycle.
- rst=1 in any state: next cycle is IDLE with counters 0. No en, bias_en or done is emitted for the aborted pass.
- N_TAPS=1: sel=1 on every consumed beat; RUN lasts one consume per neuron.
- N_NEURONS=1: the first WRITE also asserts done.

## Configuration
- ACC_SEQ_CTRL_BIAS_EN defined: BIAS state exists; bias_en pulses once per neuron between the last tap and WRITE; P = N_TAPS+2.
- Undefined: no BIAS state; bias_en tied to 0; last tap goes directly to WRITE; P = N_TAPS+1.
- The port list is identical in both builds.

## Structure
- Package acc_seq_pkg holds:
  - the state enum (IDLE, RUN, BIAS, WRITE; 2-bit encoding);
  - the width helper function computing max(1,$clog2(n)).
- One sub-module, mod_counter:
  - parametrised modulo-N counter with inputs clk, rst, inc, clr;
  - outputs count and a last flag;
  - instantiated twice, for taps and for neurons.

## Test plan
- Defaults, no macro, in_valid=1, start pulse at cycle 0:
  - sel at cycles 1, 6, 11, …;
  - en at cycles 5, 10, …, 50;
  - done only at cycle 50;
  - busy is 0 at cycle 51.
- Defaults, in_valid low on cycles 2–4 of neuron 0: en moves to cycle 8; mac_en never asserts while in_valid=0; tap_idx holds at 1.
- Macro defined, N_TAPS=3, N_NEURONS=2, in_valid=1: bias_en at cycles 4 and 9; en at cycles 5 and 10; done at cycle 10.
- N_TAPS=1, N_NEURONS=1: sel and mac_en at cycle 1; en and done at cycle 2; start held high continuously restarts a pass every 3 cycles.
- rst asserted at cycle 7 mid-pass: at cycle 8 state is IDLE, tap_idx=0, neu_idx=0; en and done stay 0 until a new start.
- start pulses during RUN and during the done cycle: ignored; counts and timing are identical to a single-start run.

Source files
------------

// File: rtl/acc_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// acc_seq_pkg
// Shared definitions for the MAC accumulator sequencer:
//   - acc_state_e : controller state encoding (2 bits)
//   - width_of()  : index width helper, max(1, $clog2(n))
// -----------------------------------------------------------------------------
package acc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BIAS  = 2'd2,
        ST_WRITE = 2'd3
    } acc_state_e;

    // A single-entry counter still needs a 1-bit index port.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/acc_seq_ctrl_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Modulo-N up counter.
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset (count -> 0)
//   inc   in   advance by one; wraps to 0 after N-1
//   clr   in   synchronous clear (count -> 0), dominates inc
//   count out  current value, W bits
//   last  out  count == N-1
// -----------------------------------------------------------------------------
module mod_counter
    import acc_seq_pkg::*;
#(
    parameter int N = 4,
    parameter int W = width_of(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         last
);

    assign last = (count == W'(N - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/acc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// acc_seq_ctrl
// Sequencer for the MAC accumulator of one neuron lane of a fully-connected
// layer. Per start it walks N_NEURONS neurons; each neuron consumes N_TAPS
// products from the streamer, optionally adds a bias, then writes the sum.
//
// Optional feature macro: ACC_SEQ_CTRL_BIAS_EN
//   defined   -> one BIAS cycle (bias_en=1) between last tap and WRITE
//   undefined -> no BIAS state, bias_en tied to 0
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      begin a layer pass (only looked at in IDLE)
//   in_valid   streamer offers a product
//   in_ready   controller accepts products (RUN)
//   mac_en     product consumed this cycle
//   sel        accumulator loads (first tap) instead of adding
//   bias_en    accumulator adds bias
//   en         output register captures the neuron sum
//   tap_idx    current tap index
//   neu_idx    current neuron index
//   busy       pass in progress
//   done       one-cycle pulse together with the last neuron's en
//
// Handshake: a product transfers on a cycle where in_valid && in_ready; the
// streamer holds its product while in_ready is low, and the controller never
// consumes without in_valid. Counters and state hold on stalled cycles.
// -----------------------------------------------------------------------------
module acc_seq_ctrl
    import acc_seq_pkg::*;
#(
    parameter int N_TAPS    = 4,
    parameter int N_NEURONS = 10,
    parameter int TAP_W     = width_of(N_TAPS),
    parameter int NEU_W     = width_of(N_NEURONS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mac_en,
    output logic             sel,
    output logic             bias_en,
    output logic             en,
    output logic [TAP_W-1:0] tap_idx,
    output logic [NEU_W-1:0] neu_idx,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_WRITE = ST_WRITE;
`ifdef ACC_SEQ_CTRL_BIAS_EN
    localparam logic [1:0] S_BIAS  = ST_BIAS;
`endif

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       tap_last;
    logic       neu_last;
    logic       in_idle;

    // ---------------- output decode (state, counters, in_valid only) -------
    assign in_idle  = (state == S_IDLE);
    assign busy     = !in_idle;
    assign in_ready = (state == S_RUN);
    assign mac_en   = in_ready && in_valid;
    assign sel      = mac_en && (tap_idx == '0);
    assign en       = (state == S_WRITE);
    assign done     = en && neu_last;
`ifdef ACC_SEQ_CTRL_BIAS_EN
    assign bias_en  = (state == S_BIAS);
`else
    assign bias_en  = 1'b0;
`endif

    // ---------------- counters ---------------------------------------------
    // Both counters wrap on their own last value; the IDLE clear keeps them
    // pinned at 0 between passes regardless of how the last pass ended.
    mod_counter #(
        .N (N_TAPS),
        .W (TAP_W)
    ) u_tap_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mac_en),
        .clr   (in_idle),
        .count (tap_idx),
        .last  (tap_last)
    );

    mod_counter #(
        .N (N_NEURONS),
        .W (NEU_W)
    ) u_neu_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (en),
        .clr   (in_idle),
        .count (neu_idx),
        .last  (neu_last)
    );

    // ---------------- state machine ----------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (mac_en && tap_last) begin
`ifdef ACC_SEQ_CTRL_BIAS_EN
                    state_nxt = S_BIAS;
`else
                    state_nxt = S_WRITE;
`endif
                end
            end
`ifdef ACC_SEQ_CTRL_BIAS_EN
            S_BIAS: begin
                state_nxt = S_WRITE;
            end
`endif
            S_WRITE: begin
                state_nxt = neu_last ? S_IDLE : S_RUN;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

endmodule
